// File: rtl/traductor_pkg.sv
// Shared definitions for the multiplexed hex display translator.
package traductor_pkg;

  typedef logic [6:0] seg_t;

  // Active-high segment codes {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam seg_t SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam seg_t SEG_APAGADO = 7'h00;

endpackage

// File: rtl/traductor_hex.sv
// Combinational nibble to active-high seven-segment code lookup.
module traductor_hex
  import traductor_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/traductor_multiplexado.sv
// Time-multiplexed driver for DIGITOS common-anode seven-segment digits.
// Optional leading-zero blanking is compiled in when TRADUCTOR_LZB_EN is defined.
module traductor_multiplexado
  import traductor_pkg::*;
#(
  parameter int unsigned DIGITOS = 4,
  parameter int unsigned DIV     = 50000
) (
  input  logic                   reloj,
  input  logic                   reset,
  input  logic [4*DIGITOS-1:0]   entrada,
  input  logic [DIGITOS-1:0]     punto,
  input  logic [DIGITOS-1:0]     apagar,
  input  logic                   cargar,
  output logic [6:0]             sal,
  output logic                   dp,
  output logic [DIGITOS-1:0]     anodo
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   tick;
  logic [4*DIGITOS-1:0]   val_r;
  logic [DIGITOS-1:0]     pto_r;
  logic [DIGITOS-1:0]     apg_r;

  logic [3:0]             nib;
  logic                   pto_sel;
  logic                   apg_sel;
  logic [DIGITOS-1:0]     onehot;
  logic                   blank;
  seg_t                   seg;

  assign tick = (cnt == CW'(DIV - 1));

  // Refresh divider and digit scan index.
  always_ff @(posedge reloj) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IW'(DIGITOS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow registers: only a load strobe updates what is displayed.
  always_ff @(posedge reloj) begin
    if (reset) begin
      val_r <= '0;
      pto_r <= '0;
      apg_r <= '0;
    end else if (cargar) begin
      val_r <= entrada;
      pto_r <= punto;
      apg_r <= apagar;
    end
  end

  // Select the nibble and per-digit flags of the digit being scanned.
  always_comb begin
    nib     = 4'h0;
    pto_sel = 1'b0;
    apg_sel = 1'b0;
    onehot  = '0;
    for (int i = 0; i < int'(DIGITOS); i++) begin
      if (idx == IW'(i)) begin
        nib       = val_r[4*i +: 4];
        pto_sel   = pto_r[i];
        apg_sel   = apg_r[i];
        onehot[i] = 1'b1;
      end
    end
  end

`ifdef TRADUCTOR_LZB_EN
  logic [DIGITOS-1:0] supr;
  logic               supr_sel;

  // Digit i>=1 is suppressed when it and every higher nibble are zero.
  always_comb begin
    logic zero_hi;
    zero_hi = 1'b1;
    supr    = '0;
    for (int i = int'(DIGITOS) - 1; i >= 1; i--) begin
      zero_hi = zero_hi && (val_r[4*i +: 4] == 4'h0);
      supr[i] = zero_hi;
    end
  end

  // Suppression flag of the digit being scanned.
  always_comb begin
    supr_sel = 1'b0;
    for (int i = 0; i < int'(DIGITOS); i++) begin
      if (idx == IW'(i)) supr_sel = supr[i];
    end
  end

  assign blank = apg_sel | supr_sel;
`else
  assign blank = apg_sel;
`endif

  traductor_hex u_hex (
    .nibble (nib),
    .seg    (seg)
  );

  // Registered outputs, all active-low.
  always_ff @(posedge reloj) begin
    if (reset || blank) begin
      sal   <= ~SEG_APAGADO;
      dp    <= 1'b1;
      anodo <= '1;
    end else begin
      sal   <= ~seg;
      dp    <= ~pto_sel;
      anodo <= ~onehot;
    end
  end

endmodule

// File: tb/tb_traductor_multiplexado.sv
// Scoreboard bench: a reference model pushes the expected outputs for every
// clock edge into a queue; a monitor pops and compares on the falling edge.
module tb_traductor_multiplexado;

  localparam int ND = 4;
  localparam int NV = 4;

  logic        reloj = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] entrada = '0;
  logic [3:0]  punto = '0;
  logic [3:0]  apagar = '0;
  logic        cargar = 1'b0;
  logic [6:0]  sal;
  logic        dp;
  logic [3:0]  anodo;
  logic [6:0]  sal1;
  logic        dp1;
  logic [0:0]  anodo1;

  always #5 reloj = ~reloj;

  traductor_multiplexado #(.DIGITOS(ND), .DIV(NV)) dut (
    .reloj   (reloj),
    .reset   (reset),
    .entrada (entrada),
    .punto   (punto),
    .apagar  (apagar),
    .cargar  (cargar),
    .sal     (sal),
    .dp      (dp),
    .anodo   (anodo)
  );

  // Single digit, refreshed every cycle.
  traductor_multiplexado #(.DIGITOS(1), .DIV(1)) dut1 (
    .reloj   (reloj),
    .reset   (reset),
    .entrada (entrada[3:0]),
    .punto   (punto[0]),
    .apagar  (apagar[0]),
    .cargar  (cargar),
    .sal     (sal1),
    .dp      (dp1),
    .anodo   (anodo1)
  );

  typedef struct packed {
    logic [6:0] sal;
    logic       dp;
    logic [3:0] an;
    logic [6:0] sal1;
    logic       dp1;
    logic       an1;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  logic [6:0] tbl [16];
  initial begin
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  end

  // Model state: shadow copy and number of edges since reset released.
  logic [15:0] m_val = '0;
  logic [3:0]  m_pto = '0;
  logic [3:0]  m_apg = '0;
  int          m_t = 0;

  function automatic void digit(input int n, input int i, input logic [15:0] v,
                                input logic [3:0] p, input logic [3:0] a,
                                output logic [6:0] s, output logic d,
                                output logic [3:0] an);
    logic b;
    b = a[i];
`ifdef TRADUCTOR_LZB_EN
    if (i >= 1 && (v >> (4 * i)) == 16'h0) b = 1'b1;
`endif
    if (b) begin
      s = 7'h7F; d = 1'b1; an = 4'hF;
    end else begin
      s  = ~tbl[(v >> (4 * i)) & 16'hF];
      d  = ~p[i];
      an = ~(4'b1 << i);
      if (n == 1) an[3:1] = 3'b111;
    end
  endfunction

  always @(posedge reloj) begin
    exp_t e;
    logic [3:0] an1;
    if (reset) begin
      e = '{sal: 7'h7F, dp: 1'b1, an: 4'hF, sal1: 7'h7F, dp1: 1'b1, an1: 1'b1};
      m_val = '0; m_pto = '0; m_apg = '0; m_t = 0;
    end else begin
      digit(ND, (m_t / NV) % ND, m_val, m_pto, m_apg, e.sal, e.dp, e.an);
      digit(1, 0, m_val & 16'h000F, m_pto, m_apg, e.sal1, e.dp1, an1);
      e.an1 = an1[0];
      if (cargar) begin
        m_val = entrada; m_pto = punto; m_apg = apagar;
      end
      m_t++;
    end
    q.push_back(e);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare away from the edge.
  always @(negedge reloj) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("sal", {1'b0, sal}, {1'b0, e.sal});
      check("dp", {7'b0, dp}, {7'b0, e.dp});
      check("anodo", {4'b0, anodo}, {4'b0, e.an});
      check("sal1", {1'b0, sal1}, {1'b0, e.sal1});
      check("dp1", {7'b0, dp1}, {7'b0, e.dp1});
      check("anodo1", {7'b0, anodo1}, {7'b0, e.an1});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge reloj);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] a);
    entrada = v; punto = p; apagar = a; cargar = 1'b1;
    cyc(1);
    cargar = 1'b0;
  endtask

  // Wait (bounded) until the upcoming edge has the given scan position.
  task automatic wait_pos(input int cnt_v, input int idx_v);
    int guard = 0;
    while (!((m_t % NV) == cnt_v && ((m_t / NV) % ND) == idx_v) && guard < 64) begin
      cyc(1);
      guard++;
    end
    checks++;
    if (guard >= 64) begin
      errors++;
      $display("FAIL wait_pos: got timeout expected position cnt=%0d idx=%0d", cnt_v, idx_v);
    end
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(2);
    // Scan of 1234 with a decimal point on digit 2.
    load(16'h1234, 4'b0100, 4'b0000);
    cyc(20);
    // Input changes without a load must not show.
    entrada = 16'hFFFF;
    cyc(16);
    // Load coincident with tick.
    wait_pos(NV - 1, 1);
    load(16'hFFFF, 4'b0000, 4'b0000);
    cyc(16);
    load(16'h9876, 4'b1001, 4'b0010);
    cyc(17);
    load(16'h0005, 4'b0000, 4'b0000);
    cyc(17);
    load(16'h0000, 4'b0001, 4'b0000);
    cyc(17);
    load(16'h0A00, 4'b0000, 4'b0000);
    cyc(17);
    // Reset mid-scan overriding a load.
    wait_pos(1, 2);
    entrada = 16'hABCD; cargar = 1'b1; reset = 1'b1;
    cyc(1);
    cargar = 1'b0; reset = 1'b0;
    cyc(18);
    // Randomized loads, occasional resets.
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 15);
      entrada = $urandom();
      if (r < 4) entrada = entrada >> (4 * $urandom_range(1, 4));
      punto  = 4'($urandom());
      apagar = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0000;
      cargar = (r < 3) || (r == 9);
      reset  = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    cargar = 1'b0; reset = 1'b0;
    cyc(3);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
